// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared entry-type encodings and default widths for the reorder buffer
package rob_pkg;

    localparam int ROB_WIDTH_DEF    = 4;
    localparam int ROB_OP_WIDTH_DEF = 2;
    localparam int NUM_WB_DEF       = 2;
    localparam int COMMIT_WIDTH_DEF = 2;
    localparam int FULL_MARGIN_DEF  = 2;

    localparam logic [1:0] ROB_OP_REG    = 2'b00;
    localparam logic [1:0] ROB_OP_BRANCH = 2'b01;
    localparam logic [1:0] ROB_OP_STORE  = 2'b10;
    localparam logic [1:0] ROB_OP_NOP    = 2'b11;

endpackage

// File: rtl/rob_commit_select.sv
// rtl/rob_commit_select.sv - head-window scan producing the per-slot in-order retire mask
//
// Ports:
//  winValid/winReady  per-slot valid and ready of entries head+0 .. head+COMMIT_WIDTH-1
//  winType            per-slot entry type, slot k at [k*ROB_OP_WIDTH +: ROB_OP_WIDTH]
//  storeAck           load/store buffer accepted the head store this cycle
//  retire             contiguous-from-slot-0 mask of entries that retire on the next edge
module rob_commit_select
    import rob_pkg::*;
#(
    parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
    parameter int ROB_OP_WIDTH = ROB_OP_WIDTH_DEF
) (
    input  logic [COMMIT_WIDTH-1:0]              winValid,
    input  logic [COMMIT_WIDTH-1:0]              winReady,
    input  logic [COMMIT_WIDTH*ROB_OP_WIDTH-1:0] winType,
    input  logic                                 storeAck,
    output logic [COMMIT_WIDTH-1:0]              retire
);

    logic                    go;
    logic                    serial;
    logic [ROB_OP_WIDTH-1:0] slotType;

    always_comb begin
        retire   = '0;
        go       = 1'b1;
        serial   = 1'b0;
        slotType = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            slotType = winType[k*ROB_OP_WIDTH +: ROB_OP_WIDTH];
            // Branches and stores have side effects resolved at the head, so they
            // may only leave from slot 0 and nothing behind them goes in the same group.
            serial   = (slotType == ROB_OP_WIDTH'(ROB_OP_BRANCH)) ||
                       (slotType == ROB_OP_WIDTH'(ROB_OP_STORE));
            if (!go || !winValid[k] || !winReady[k]) begin
                go = 1'b0;
            end else if (k == 0) begin
                if (slotType == ROB_OP_WIDTH'(ROB_OP_STORE) && !storeAck) begin
                    go = 1'b0;
                end else begin
                    retire[k] = 1'b1;
                    if (serial) go = 1'b0;
                end
            end else if (serial) begin
                go = 1'b0;
            end else begin
                retire[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// rtl/rob_multi_commit.sv - reorder buffer with multi-channel writeback, multi-slot commit and store handshake
//
// Ports:
//  clockIn, resetIn                 clock, asynchronous active-high reset
//  clear, newPc                     one-cycle flush pulse and restart PC on branch mispredict
//  wbValid/wbRobIndex/wbValue/wbJump writeback channels (higher channel wins on index clash)
//  addValid/addType/addReady/addValue/addPredJump/addDest/addAltPc  allocation at index next
//  full, next, freeCount            allocation status
//  rsNDep -> rsNReady/rsNValue      operand lookup with same-cycle writeback forwarding
//  regUpdateValid/Dest/regValue/regUpdateRobId  registered register-file commit, one slot per retirement
//  storeCommitValid/RobId/Ack       head store handshake with the load/store buffer
//  robBeginId, beginValid           head index and non-empty flag
module rob_multi_commit
    import rob_pkg::*;
#(
    parameter int ROB_WIDTH    = ROB_WIDTH_DEF,
    parameter int ROB_OP_WIDTH = ROB_OP_WIDTH_DEF,
    parameter int NUM_WB       = NUM_WB_DEF,
    parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
    parameter int FULL_MARGIN  = FULL_MARGIN_DEF
) (
    input  logic                           clockIn,
    input  logic                           resetIn,
    output logic                           clear,
    output logic [31:0]                    newPc,
    input  logic [NUM_WB-1:0]              wbValid,
    input  logic [NUM_WB*ROB_WIDTH-1:0]    wbRobIndex,
    input  logic [NUM_WB*32-1:0]           wbValue,
    input  logic [NUM_WB-1:0]              wbJump,
    input  logic                           addValid,
    input  logic [ROB_OP_WIDTH-1:0]        addType,
    input  logic                           addReady,
    input  logic [31:0]                    addValue,
    input  logic                           addPredJump,
    input  logic [4:0]                     addDest,
    input  logic [31:0]                    addAltPc,
    output logic                           full,
    output logic [ROB_WIDTH-1:0]           next,
    output logic [ROB_WIDTH:0]             freeCount,
    input  logic [ROB_WIDTH-1:0]           rs1Dep,
    input  logic [ROB_WIDTH-1:0]           rs2Dep,
    output logic                           rs1Ready,
    output logic                           rs2Ready,
    output logic [31:0]                    rs1Value,
    output logic [31:0]                    rs2Value,
    output logic [COMMIT_WIDTH-1:0]        regUpdateValid,
    output logic [COMMIT_WIDTH*5-1:0]      regUpdateDest,
    output logic [COMMIT_WIDTH*32-1:0]     regValue,
    output logic [COMMIT_WIDTH*ROB_WIDTH-1:0] regUpdateRobId,
    output logic                           storeCommitValid,
    output logic [ROB_WIDTH-1:0]           storeCommitRobId,
    input  logic                           storeCommitAck,
    output logic [ROB_WIDTH-1:0]           robBeginId,
    output logic                           beginValid
);

    localparam int ROB_SIZE = 1 << ROB_WIDTH;
    localparam int CNT_W    = ROB_WIDTH + 1;

    logic [ROB_SIZE-1:0]     entValid;
    logic [ROB_SIZE-1:0]     entReady;
    logic [ROB_SIZE-1:0]     entPred;
    logic [ROB_SIZE-1:0]     entAct;
    logic [ROB_OP_WIDTH-1:0] entType  [ROB_SIZE];
    logic [31:0]             entValue [ROB_SIZE];
    logic [4:0]              entDest  [ROB_SIZE];
    logic [31:0]             entAlt   [ROB_SIZE];

    logic [ROB_WIDTH-1:0]    beginPtr;
    logic [ROB_WIDTH-1:0]    endPtr;
    logic [CNT_W-1:0]        count;

    logic [ROB_WIDTH-1:0]              winIdx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]           winValid;
    logic [COMMIT_WIDTH-1:0]           winReady;
    logic [COMMIT_WIDTH*ROB_OP_WIDTH-1:0] winType;
    logic [COMMIT_WIDTH-1:0]           retire;
    logic [CNT_W-1:0]                  retireCnt;

    logic headOk;
    logic mispredict;
    logic addAccept;
    logic rs1Fwd, rs2Fwd;
    logic [31:0] rs1FwdVal, rs2FwdVal;

    always_comb begin
        winValid  = '0;
        winReady  = '0;
        winType   = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            winIdx[k] = beginPtr + ROB_WIDTH'(k);
            winValid[k] = entValid[winIdx[k]];
            winReady[k] = entReady[winIdx[k]];
            winType[k*ROB_OP_WIDTH +: ROB_OP_WIDTH] = entType[winIdx[k]];
        end
    end

    rob_commit_select #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .ROB_OP_WIDTH (ROB_OP_WIDTH)
    ) u_select (
        .winValid (winValid),
        .winReady (winReady),
        .winType  (winType),
        .storeAck (storeCommitAck),
        .retire   (retire)
    );

    // The retire mask is contiguous from slot 0, so its popcount is the head advance.
    always_comb begin
        retireCnt = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            retireCnt = retireCnt + CNT_W'(retire[k]);
        end
    end

    assign headOk     = entValid[beginPtr] && entReady[beginPtr];
    assign mispredict = !clear && headOk &&
                        (entType[beginPtr] == ROB_OP_WIDTH'(ROB_OP_BRANCH)) &&
                        (entAct[beginPtr] != entPred[beginPtr]);
    assign addAccept  = addValid && !clear && (count != CNT_W'(ROB_SIZE));

    assign storeCommitValid = !clear && headOk &&
                              (entType[beginPtr] == ROB_OP_WIDTH'(ROB_OP_STORE));
    assign storeCommitRobId = storeCommitValid ? beginPtr : '0;

    assign freeCount  = CNT_W'(ROB_SIZE) - count;
    assign full       = freeCount <= CNT_W'(FULL_MARGIN);
    assign next       = endPtr;
    assign robBeginId = beginPtr;
    assign beginValid = (count != '0);

    // Ascending scan: the last matching channel (highest) supplies the forwarded value.
    always_comb begin
        rs1Fwd    = 1'b0;
        rs2Fwd    = 1'b0;
        rs1FwdVal = '0;
        rs2FwdVal = '0;
        for (int c = 0; c < NUM_WB; c++) begin
            if (wbValid[c] && wbRobIndex[c*ROB_WIDTH +: ROB_WIDTH] == rs1Dep) begin
                rs1Fwd    = 1'b1;
                rs1FwdVal = wbValue[c*32 +: 32];
            end
            if (wbValid[c] && wbRobIndex[c*ROB_WIDTH +: ROB_WIDTH] == rs2Dep) begin
                rs2Fwd    = 1'b1;
                rs2FwdVal = wbValue[c*32 +: 32];
            end
        end
    end

    assign rs1Ready = rs1Fwd || (entValid[rs1Dep] && entReady[rs1Dep]);
    assign rs2Ready = rs2Fwd || (entValid[rs2Dep] && entReady[rs2Dep]);
    assign rs1Value = rs1Fwd ? rs1FwdVal :
                      (entValid[rs1Dep] && entReady[rs1Dep]) ? entValue[rs1Dep] : 32'd0;
    assign rs2Value = rs2Fwd ? rs2FwdVal :
                      (entValid[rs2Dep] && entReady[rs2Dep]) ? entValue[rs2Dep] : 32'd0;

    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            entValid       <= '0;
            entReady       <= '0;
            entPred        <= '0;
            entAct         <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entType[i]  <= '0;
                entValue[i] <= '0;
                entDest[i]  <= '0;
                entAlt[i]   <= '0;
            end
            beginPtr       <= '0;
            endPtr         <= '0;
            count          <= '0;
            clear          <= 1'b0;
            newPc          <= '0;
            regUpdateValid <= '0;
            regUpdateDest  <= '0;
            regValue       <= '0;
            regUpdateRobId <= '0;
        end else begin
            clear          <= 1'b0;
            newPc          <= '0;
            regUpdateValid <= '0;
            regUpdateDest  <= '0;
            regValue       <= '0;
            regUpdateRobId <= '0;
            if (clear) begin
                // Flush cycle: the front end is restarting, drop everything presented.
            end else if (mispredict) begin
                clear    <= 1'b1;
                newPc    <= entAlt[beginPtr];
                entValid <= '0;
                beginPtr <= '0;
                endPtr   <= '0;
                count    <= '0;
            end else begin
                for (int c = 0; c < NUM_WB; c++) begin
                    if (wbValid[c] && entValid[wbRobIndex[c*ROB_WIDTH +: ROB_WIDTH]]) begin
                        entValue[wbRobIndex[c*ROB_WIDTH +: ROB_WIDTH]] <= wbValue[c*32 +: 32];
                        entReady[wbRobIndex[c*ROB_WIDTH +: ROB_WIDTH]] <= 1'b1;
                        entAct[wbRobIndex[c*ROB_WIDTH +: ROB_WIDTH]]   <= wbJump[c];
                    end
                end
                for (int k = 0; k < COMMIT_WIDTH; k++) begin
                    if (retire[k]) begin
                        entValid[winIdx[k]] <= 1'b0;
                        regUpdateValid[k]   <= (entType[winIdx[k]] == ROB_OP_WIDTH'(ROB_OP_REG)) &&
                                               (entDest[winIdx[k]] != 5'd0);
                        regUpdateDest[k*5 +: 5]                  <= entDest[winIdx[k]];
                        regValue[k*32 +: 32]                     <= entValue[winIdx[k]];
                        regUpdateRobId[k*ROB_WIDTH +: ROB_WIDTH] <= winIdx[k];
                    end
                end
                // Allocation is rejected at count==ROB_SIZE, so endPtr never aliases a retiring slot.
                if (addAccept) begin
                    entValid[endPtr] <= 1'b1;
                    entReady[endPtr] <= addReady;
                    entPred[endPtr]  <= addPredJump;
                    entAct[endPtr]   <= 1'b0;
                    entType[endPtr]  <= addType;
                    entValue[endPtr] <= addValue;
                    entDest[endPtr]  <= addDest;
                    entAlt[endPtr]   <= addAltPc;
                    endPtr           <= endPtr + 1'b1;
                end
                beginPtr <= beginPtr + ROB_WIDTH'(retireCnt);
                count    <= count + CNT_W'(addAccept) - retireCnt;
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// tb/tb_rob_multi_commit.sv - directed self-checking bench for rob_multi_commit
module tb_rob_multi_commit;

    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        clear;
    logic [31:0] newPc;
    logic [1:0]  wbValid;
    logic [7:0]  wbRobIndex;
    logic [63:0] wbValue;
    logic [1:0]  wbJump;
    logic        addValid;
    logic [1:0]  addType;
    logic        addReady;
    logic [31:0] addValue;
    logic        addPredJump;
    logic [4:0]  addDest;
    logic [31:0] addAltPc;
    logic        full;
    logic [3:0]  next;
    logic [4:0]  freeCount;
    logic [3:0]  rs1Dep, rs2Dep;
    logic        rs1Ready, rs2Ready;
    logic [31:0] rs1Value, rs2Value;
    logic [1:0]  regUpdateValid;
    logic [9:0]  regUpdateDest;
    logic [63:0] regValue;
    logic [7:0]  regUpdateRobId;
    logic        storeCommitValid;
    logic [3:0]  storeCommitRobId;
    logic        storeCommitAck;
    logic [3:0]  robBeginId;
    logic        beginValid;

    int checks = 0;
    int fails  = 0;

    always #5 clockIn = ~clockIn;

    rob_multi_commit dut (
        .clockIn(clockIn), .resetIn(resetIn), .clear(clear), .newPc(newPc),
        .wbValid(wbValid), .wbRobIndex(wbRobIndex), .wbValue(wbValue), .wbJump(wbJump),
        .addValid(addValid), .addType(addType), .addReady(addReady), .addValue(addValue),
        .addPredJump(addPredJump), .addDest(addDest), .addAltPc(addAltPc),
        .full(full), .next(next), .freeCount(freeCount),
        .rs1Dep(rs1Dep), .rs2Dep(rs2Dep), .rs1Ready(rs1Ready), .rs2Ready(rs2Ready),
        .rs1Value(rs1Value), .rs2Value(rs2Value),
        .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
        .regValue(regValue), .regUpdateRobId(regUpdateRobId),
        .storeCommitValid(storeCommitValid), .storeCommitRobId(storeCommitRobId),
        .storeCommitAck(storeCommitAck), .robBeginId(robBeginId), .beginValid(beginValid)
    );

    task automatic idle();
        wbValid = '0; wbRobIndex = '0; wbValue = '0; wbJump = '0;
        addValid = 0; addType = '0; addReady = 0; addValue = '0;
        addPredJump = 0; addDest = '0; addAltPc = '0;
        rs1Dep = '0; rs2Dep = '0; storeCommitAck = 0;
    endtask

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic setAdd(input logic [1:0] t, input logic rdy, input logic [31:0] v,
                          input logic pj, input logic [4:0] d, input logic [31:0] alt);
        addValid = 1; addType = t; addReady = rdy; addValue = v;
        addPredJump = pj; addDest = d; addAltPc = alt;
    endtask

    task automatic doReset();
        idle();
        resetIn = 1;
        repeat (2) @(posedge clockIn);
        #1;
        resetIn = 0;
    endtask

    task automatic test_reset();
        idle();
        resetIn = 1;
        #3;
        checks++; if (freeCount !== 5'd16) begin fails++; $display("FAIL reset_free: got %0d want 16", freeCount); end
        checks++; if (full !== 1'b0 || clear !== 1'b0 || beginValid !== 1'b0) begin fails++; $display("FAIL reset_flags: got full=%b clear=%b bv=%b want 0", full, clear, beginValid); end
        checks++; if (next !== 4'd0 || newPc !== 32'd0 || regUpdateValid !== 2'b00 || storeCommitValid !== 1'b0) begin fails++; $display("FAIL reset_outs: got next=%0d pc=%h ruv=%b scv=%b want 0", next, newPc, regUpdateValid, storeCommitValid); end
        doReset();
    endtask

    task automatic test_commit_group();
        doReset();
        setAdd(2'b00, 0, 32'h11, 0, 5'd5, 0); tick();
        setAdd(2'b00, 1, 32'h22, 0, 5'd6, 0); tick();
        checks++; if (regUpdateValid !== 2'b00) begin fails++; $display("FAIL grp_blocked: got %b want 00", regUpdateValid); end
        setAdd(2'b00, 1, 32'h33, 0, 5'd7, 0);
        wbValid = 2'b01; wbRobIndex = 8'h00; wbValue = {32'h0, 32'h44};
        tick();
        idle(); tick();
        checks++; if (regUpdateValid !== 2'b11) begin fails++; $display("FAIL grp_two_valid: got %b want 11", regUpdateValid); end
        checks++; if (regUpdateDest !== {5'd6, 5'd5}) begin fails++; $display("FAIL grp_two_dest: got %h want %h", regUpdateDest, {5'd6, 5'd5}); end
        checks++; if (regValue !== {32'h22, 32'h44}) begin fails++; $display("FAIL grp_two_value: got %h want %h", regValue, {32'h22, 32'h44}); end
        tick();
        checks++; if (regUpdateValid !== 2'b01 || regUpdateDest[4:0] !== 5'd7 || regUpdateRobId[3:0] !== 4'd2) begin fails++; $display("FAIL grp_third: got v=%b d=%0d id=%0d want 01 7 2", regUpdateValid, regUpdateDest[4:0], regUpdateRobId[3:0]); end
        tick();
        checks++; if (regUpdateValid !== 2'b00 || beginValid !== 1'b0 || freeCount !== 5'd16) begin fails++; $display("FAIL grp_empty: got v=%b bv=%b free=%0d want 00 0 16", regUpdateValid, beginValid, freeCount); end
    endtask

    task automatic test_full();
        doReset();
        for (int i = 0; i < 13; i++) begin setAdd(2'b00, 0, i, 0, 5'd1, 0); tick(); end
        checks++; if (full !== 1'b0 || freeCount !== 5'd3) begin fails++; $display("FAIL full13: got full=%b free=%0d want 0 3", full, freeCount); end
        tick();
        checks++; if (full !== 1'b1 || freeCount !== 5'd2 || next !== 4'd14) begin fails++; $display("FAIL full14: got full=%b free=%0d next=%0d want 1 2 14", full, freeCount, next); end
        idle(); wbValid = 2'b01; wbRobIndex = 8'h00; wbValue = 64'd7; tick();
        idle(); tick();
        checks++; if (full !== 1'b0 || freeCount !== 5'd3 || regUpdateValid !== 2'b01) begin fails++; $display("FAIL full_retire: got full=%b free=%0d ruv=%b want 0 3 01", full, freeCount, regUpdateValid); end
        for (int i = 0; i < 3; i++) begin setAdd(2'b00, 0, 0, 0, 5'd1, 0); tick(); end
        checks++; if (freeCount !== 5'd0 || next !== 4'd1) begin fails++; $display("FAIL full_16: got free=%0d next=%0d want 0 1", freeCount, next); end
        setAdd(2'b00, 0, 0, 0, 5'd2, 0); tick(); idle();
        checks++; if (freeCount !== 5'd0 || next !== 4'd1 || full !== 1'b1) begin fails++; $display("FAIL full_ignore: got free=%0d next=%0d full=%b want 0 1 1", freeCount, next, full); end
    endtask

    task automatic test_forward();
        doReset();
        for (int i = 0; i < 4; i++) begin setAdd(2'b00, 0, 0, 0, 5'd3, 0); tick(); end
        idle(); rs1Dep = 4'd3; rs2Dep = 4'd2; #1;
        checks++; if (rs1Ready !== 1'b0) begin fails++; $display("FAIL fwd_notready: got %b want 0", rs1Ready); end
        wbValid = 2'b01; wbRobIndex = 8'h03; wbValue = {32'h0, 32'h55}; #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'h55 || rs2Ready !== 1'b0) begin fails++; $display("FAIL fwd_same_cycle: got r=%b v=%h r2=%b want 1 55 0", rs1Ready, rs1Value, rs2Ready); end
        tick(); idle(); rs1Dep = 4'd3; #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'h55) begin fails++; $display("FAIL fwd_stored: got r=%b v=%h want 1 55", rs1Ready, rs1Value); end
        setAdd(2'b00, 0, 0, 0, 5'd4, 0); tick(); idle();
        wbValid = 2'b11; wbRobIndex = 8'h44; wbValue = {32'h2, 32'h1}; rs1Dep = 4'd4; #1;
        checks++; if (rs1Value !== 32'h2) begin fails++; $display("FAIL dual_fwd: got %h want 2", rs1Value); end
        tick(); idle(); rs1Dep = 4'd4; #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'h2) begin fails++; $display("FAIL dual_stored: got r=%b v=%h want 1 2", rs1Ready, rs1Value); end
        wbValid = 2'b01; wbRobIndex = 8'h09; wbValue = 64'h77; tick(); idle(); rs1Dep = 4'd9; #1;
        checks++; if (rs1Ready !== 1'b0) begin fails++; $display("FAIL wb_invalid: got %b want 0", rs1Ready); end
    endtask

    task automatic test_mispredict();
        doReset();
        setAdd(2'b01, 0, 0, 0, 5'd0, 32'h100); tick();
        setAdd(2'b00, 1, 32'h9, 0, 5'd9, 0); tick();
        idle(); wbValid = 2'b01; wbRobIndex = 8'h00; wbJump = 2'b01; tick();
        idle();
        checks++; if (clear !== 1'b0) begin fails++; $display("FAIL br_early: got %b want 0", clear); end
        tick();
        checks++; if (clear !== 1'b1 || newPc !== 32'h100) begin fails++; $display("FAIL br_clear: got clear=%b pc=%h want 1 100", clear, newPc); end
        checks++; if (beginValid !== 1'b0 || next !== 4'd0 || freeCount !== 5'd16 || regUpdateValid !== 2'b00) begin fails++; $display("FAIL br_flushed: got bv=%b next=%0d free=%0d ruv=%b want 0 0 16 00", beginValid, next, freeCount, regUpdateValid); end
        setAdd(2'b00, 1, 32'h3, 0, 5'd3, 0); tick(); idle();
        checks++; if (clear !== 1'b0 || next !== 4'd0 || beginValid !== 1'b0) begin fails++; $display("FAIL br_after: got clear=%b next=%0d bv=%b want 0 0 0", clear, next, beginValid); end
    endtask

    task automatic test_branch_correct();
        doReset();
        setAdd(2'b01, 0, 0, 1, 5'd0, 32'h200); tick();
        setAdd(2'b00, 1, 32'hA, 0, 5'd10, 0); tick();
        idle(); wbValid = 2'b01; wbRobIndex = 8'h00; wbJump = 2'b01; tick();
        idle(); tick();
        checks++; if (clear !== 1'b0 || robBeginId !== 4'd1 || regUpdateValid !== 2'b00) begin fails++; $display("FAIL brok_retire: got clear=%b head=%0d ruv=%b want 0 1 00", clear, robBeginId, regUpdateValid); end
        tick();
        checks++; if (regUpdateValid !== 2'b01 || regUpdateDest[4:0] !== 5'd10) begin fails++; $display("FAIL brok_next: got v=%b d=%0d want 01 10", regUpdateValid, regUpdateDest[4:0]); end
    endtask

    task automatic test_store();
        doReset();
        setAdd(2'b10, 1, 32'h5, 0, 5'd0, 0); tick();
        setAdd(2'b00, 1, 32'hC, 0, 5'd12, 0); #1;
        checks++; if (storeCommitValid !== 1'b1 || storeCommitRobId !== 4'd0) begin fails++; $display("FAIL st_valid: got v=%b id=%0d want 1 0", storeCommitValid, storeCommitRobId); end
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            checks++; if (storeCommitValid !== 1'b1 || robBeginId !== 4'd0 || regUpdateValid !== 2'b00) begin fails++; $display("FAIL st_hold%0d: got v=%b head=%0d ruv=%b want 1 0 00", i, storeCommitValid, robBeginId, regUpdateValid); end
            tick();
        end
        storeCommitAck = 1; tick(); storeCommitAck = 0; #1;
        checks++; if (robBeginId !== 4'd1 || storeCommitValid !== 1'b0 || regUpdateValid !== 2'b00) begin fails++; $display("FAIL st_ack: got head=%0d v=%b ruv=%b want 1 0 00", robBeginId, storeCommitValid, regUpdateValid); end
        tick();
        checks++; if (regUpdateValid !== 2'b01 || regUpdateDest[4:0] !== 5'd12) begin fails++; $display("FAIL st_after: got v=%b d=%0d want 01 12", regUpdateValid, regUpdateDest[4:0]); end
    endtask

    task automatic test_reset_midop();
        doReset();
        setAdd(2'b10, 1, 32'h5, 0, 5'd0, 0); tick(); idle(); #1;
        checks++; if (storeCommitValid !== 1'b1) begin fails++; $display("FAIL rst_pre: got %b want 1", storeCommitValid); end
        resetIn = 1; #1;
        checks++; if (storeCommitValid !== 1'b0 || beginValid !== 1'b0 || freeCount !== 5'd16) begin fails++; $display("FAIL rst_mid: got v=%b bv=%b free=%0d want 0 0 16", storeCommitValid, beginValid, freeCount); end
        @(negedge clockIn); resetIn = 0;
    endtask

    task automatic test_x0_nop();
        doReset();
        setAdd(2'b00, 1, 32'h1, 0, 5'd0, 0); tick();
        setAdd(2'b11, 1, 32'h2, 0, 5'd8, 0); tick(); idle();
        checks++; if (regUpdateValid !== 2'b00 || robBeginId !== 4'd1) begin fails++; $display("FAIL x0_retire: got v=%b head=%0d want 00 1", regUpdateValid, robBeginId); end
        tick();
        checks++; if (regUpdateValid !== 2'b00 || beginValid !== 1'b0) begin fails++; $display("FAIL nop_retire: got v=%b bv=%b want 00 0", regUpdateValid, beginValid); end
    endtask

    task automatic test_back_to_back_wrap();
        doReset();
        for (int i = 0; i < 20; i++) begin
            setAdd(2'b00, 1, i, 0, 5'((i % 31) + 1), 0);
            tick();
            if (i >= 1) begin
                checks++;
                if (regUpdateValid !== 2'b01 || regUpdateRobId[3:0] !== 4'((i - 1) % 16) ||
                    regValue[31:0] !== 32'(i - 1) || next !== 4'((i + 1) % 16) || freeCount !== 5'd15) begin
                    fails++;
                    $display("FAIL wrap%0d: got v=%b id=%0d val=%0d next=%0d free=%0d want 01 %0d %0d %0d 15",
                             i, regUpdateValid, regUpdateRobId[3:0], regValue[31:0], next, freeCount,
                             (i - 1) % 16, i - 1, (i + 1) % 16);
                end
            end
        end
        idle();
    endtask

    initial begin
        resetIn = 1;
        idle();
        test_reset();
        test_commit_group();
        test_full();
        test_forward();
        test_mispredict();
        test_branch_correct();
        test_store();
        test_reset_midop();
        test_x0_nop();
        test_back_to_back_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
